psu_rail_monitor: RTL

PSU_RAIL_MONITOR -- requirements
Module: psu_rail_monitor

---
 rtl/psu_rail_monitor.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/psu_rail_monitor.sv
// -----------------------------------------------------------------------------
// psu_rail_monitor
//
// Watches the power-good outputs of NUM_RAILS regulators against the enable
// requests coming from the PSU controller. It waits up to PG_TIMEOUT cycles for
// all requested rails to come good, then monitors them. A timeout or a lost
// rail latches a sticky fault together with the lowest offending rail index.
//
// Optional feature (macro PSU_PG_DEBOUNCE_EN):
//   defined   - each synchronized power-good bit must hold a new level for
//               DEBOUNCE consecutive cycles before it is accepted.
//   undefined - the synchronizer output is used directly.
//
// Ports:
//   clk         system clock, all state on posedge
//   rst         asynchronous, active-high reset
//   act_ctl     rail enable requests (synchronous to clk)
//   pg_in       raw power-good from the regulators (asynchronous)
//   fault_clr   single-cycle fault acknowledge
//   ready       all requested rails good, monitoring active
//   fault       sticky rail fault
//   fault_rail  index of the faulting rail, valid while fault=1
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no rail requested
// ST_WAIT_PG | rails requested, waiting for power-good, timeout running
// ST_MONITOR | all requested rails good, watching for loss of power-good
// ST_FAULT   | sticky fault, left only by fault_clr with act_ctl == 0
// -----------------------------------------------------------------------------
module psu_rail_monitor #(
  parameter int NUM_RAILS  = 5,
  parameter int PG_TIMEOUT = 400,
  parameter int DEBOUNCE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RAILS-1:0] act_ctl,
  input  logic [NUM_RAILS-1:0] pg_in,
  input  logic                 fault_clr,
  output logic                 ready,
  output logic                 fault,
  output logic [2:0]           fault_rail
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_PG,
    ST_MONITOR,
    ST_FAULT
  } state_t;

  logic [NUM_RAILS-1:0] sync1_q;
  logic [NUM_RAILS-1:0] sync2_q;
  logic [NUM_RAILS-1:0] pg_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pg_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PSU_PG_DEBOUNCE_EN
  // The counter only ever needs to reach DEBOUNCE-1: the DEBOUNCE-th differing
  // cycle updates pg_stable and clears the counter in the same edge.
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [NUM_RAILS-1:0] pg_stable_q;
  logic [CNT_W-1:0]     db_cnt_q [NUM_RAILS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_stable_q <= '0;
      for (int i = 0; i < NUM_RAILS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RAILS; i++) begin
        if (sync2_q[i] == pg_stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
          pg_stable_q[i] <= sync2_q[i];
          db_cnt_q[i]    <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign pg_stable = pg_stable_q;
`else
  assign pg_stable = sync2_q;
`endif

  state_t               state_q;
  logic [NUM_RAILS-1:0] en_mask_q;
  logic [15:0]          timer_q;
  logic                 ready_q;
  logic                 fault_q;
  logic [2:0]           fault_rail_q;

  logic [NUM_RAILS-1:0] missing;
  logic [NUM_RAILS-1:0] lost;
  logic [NUM_RAILS-1:0] added;
  logic                 act_none;
  logic                 timeout_hit;

  assign missing     = act_ctl & ~pg_stable;
  assign lost        = en_mask_q & missing;
  assign added       = act_ctl & ~en_mask_q;
  assign act_none    = (act_ctl == '0);
  assign timeout_hit = (timer_q == 16'(PG_TIMEOUT - 1));

  function automatic logic [2:0] lowest_idx(input logic [NUM_RAILS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      en_mask_q    <= '0;
      timer_q      <= '0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!act_none) begin
            state_q   <= ST_WAIT_PG;
            en_mask_q <= act_ctl;
            timer_q   <= '0;
          end
        end

        ST_WAIT_PG: begin
          // act_ctl == 0 must be tested first: with no request the
          // all-good condition is trivially true.
          if (act_none) begin
            state_q   <= ST_IDLE;
            en_mask_q <= '0;
            timer_q   <= '0;
          end else if (missing == '0) begin
            state_q   <= ST_MONITOR;
            en_mask_q <= act_ctl;
            ready_q   <= 1'b1;
          end else if (timeout_hit) begin
            state_q      <= ST_FAULT;
            en_mask_q    <= act_ctl;
            fault_q      <= 1'b1;
            fault_rail_q <= lowest_idx(missing);
          end else begin
            // request changes track into the mask without restarting the timer
            en_mask_q <= act_ctl;
            timer_q   <= timer_q + 16'd1;
          end
        end

        ST_MONITOR: begin
          if (lost != '0) begin
            state_q      <= ST_FAULT;
            ready_q      <= 1'b0;
            fault_q      <= 1'b1;
            fault_rail_q <= lowest_idx(lost);
          end else if (added != '0) begin
            state_q   <= ST_WAIT_PG;
            en_mask_q <= act_ctl;
            timer_q   <= '0;
            ready_q   <= 1'b0;
          end else if (act_none) begin
            state_q   <= ST_IDLE;
            en_mask_q <= '0;
            ready_q   <= 1'b0;
          end else begin
            en_mask_q <= en_mask_q & act_ctl;
          end
        end

        ST_FAULT: begin
          if (fault_clr && act_none) begin
            state_q      <= ST_IDLE;
            en_mask_q    <= '0;
            timer_q      <= '0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          en_mask_q    <= '0;
          timer_q      <= '0;
          ready_q      <= 1'b0;
          fault_q      <= 1'b0;
          fault_rail_q <= '0;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;

endmodule
